// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load writeback results into a single register-file write port through a circular FIFO.
// Optional macro WB_BYPASS_EN lets a lone result skip an empty FIFO, saving one cycle of latency.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   AluValid,
    output logic                   AluReady,
    input  logic [5:0]             AluRd,
    input  logic [XLEN-1:0]        AluData,
    input  logic                   MemValid,
    output logic                   MemReady,
    input  logic [5:0]             MemRd,
    input  logic [XLEN-1:0]        MemData,
    output logic                   RegWrite,
    output logic [5:0]             WriteReg,
    output logic [XLEN-1:0]        WriteData,
    output logic [$clog2(DEPTH):0] Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [5:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    // Register indices 0 and 32..63 carry no architectural write.
    function automatic logic rd_writable(input logic [5:0] rd);
        return (rd != 6'd0) && (rd[5] == 1'b0);
    endfunction

    entry_t          fifo_r [DEPTH];
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic            reg_write_r;
    logic [5:0]      write_reg_r;
    logic [XLEN-1:0] write_data_r;

    logic [CW-1:0]   free_s;
    logic            mem_ready_s;
    logic            alu_ready_s;
    logic            mem_acc_s;
    logic            alu_acc_s;
    logic            pop_s;
    entry_t          mem_entry_s;
    entry_t          alu_entry_s;
    entry_t          head_entry_s;
    entry_t          push0_s;
    entry_t          push1_s;
    entry_t          byp_s;
    logic            push0_en_s;
    logic            push1_en_s;
    logic            byp_en_s;
    logic [PW-1:0]   tail_p1_s;
    logic [CW-1:0]   push_cnt_s;
    logic [CW-1:0]   count_nxt_s;

    // Handshake: readiness uses registered occupancy only, a same-edge pop is not credited.
    always_comb begin
        free_s       = DEPTH_C - count_r;
        mem_ready_s  = rst_n && (free_s >= CW'(1));
        alu_ready_s  = rst_n && ((free_s >= CW'(2)) || ((free_s == CW'(1)) && !MemValid));
        mem_acc_s    = MemValid && mem_ready_s;
        alu_acc_s    = AluValid && alu_ready_s;
        pop_s        = (count_r != {CW{1'b0}});
        mem_entry_s  = '{rd: MemRd, data: MemData};
        alu_entry_s  = '{rd: AluRd, data: AluData};
        head_entry_s = fifo_r[head_r];
    end

    // Routing of accepted results: MEM is older, so it takes the first slot (or the bypass).
    always_comb begin
        push0_en_s = 1'b0;
        push0_s    = '0;
        push1_en_s = 1'b0;
        push1_s    = '0;
        byp_en_s   = 1'b0;
        byp_s      = '0;
`ifdef WB_BYPASS_EN
        if (!pop_s && mem_acc_s) begin
            byp_en_s   = 1'b1;
            byp_s      = mem_entry_s;
            push0_en_s = alu_acc_s;
            push0_s    = alu_entry_s;
        end else if (!pop_s && alu_acc_s) begin
            byp_en_s   = 1'b1;
            byp_s      = alu_entry_s;
        end else if (mem_acc_s) begin
`else
        if (mem_acc_s) begin
`endif
            push0_en_s = 1'b1;
            push0_s    = mem_entry_s;
            push1_en_s = alu_acc_s;
            push1_s    = alu_entry_s;
        end else if (alu_acc_s) begin
            push0_en_s = 1'b1;
            push0_s    = alu_entry_s;
        end else begin
            push0_en_s = 1'b0;
        end
    end

    // Next-state arithmetic for pointers and occupancy.
    always_comb begin
        tail_p1_s   = tail_r + PW'(1);
        push_cnt_s  = CW'(push0_en_s) + CW'(push1_en_s);
        count_nxt_s = count_r + push_cnt_s - CW'(pop_s);
    end

    // Pointer and occupancy state; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= pop_s ? (head_r + PW'(1)) : head_r;
            tail_r  <= tail_r + PW'(push_cnt_s);
            count_r <= count_nxt_s;
        end
    end

    // Storage array; left unreset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push0_en_s) begin
            fifo_r[tail_r] <= push0_s;
        end
        if (push1_en_s) begin
            fifo_r[tail_p1_s] <= push1_s;
        end
    end

    // Register-file write port: pop the head, else take a bypassed result, else idle holding data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= 6'd0;
            write_data_r <= {XLEN{1'b0}};
        end else if (pop_s) begin
            reg_write_r  <= rd_writable(head_entry_s.rd);
            write_reg_r  <= head_entry_s.rd;
            write_data_r <= head_entry_s.data;
        end else if (byp_en_s) begin
            reg_write_r  <= rd_writable(byp_s.rd);
            write_reg_r  <= byp_s.rd;
            write_data_r <= byp_s.data;
        end else begin
            reg_write_r  <= 1'b0;
        end
    end

    assign MemReady  = mem_ready_s;
    assign AluReady  = alu_ready_s;
    assign RegWrite  = reg_write_r;
    assign WriteReg  = write_reg_r;
    assign WriteData = write_data_r;
    assign Count     = count_r;

endmodule
